fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller that sequences the operand-select muxes in front of the ALU, branch comparator and store-data path.
- Sits at the decode/execute boundary.
- Tracks in-flight destination registers in a small scoreboard pipe.
- Produces registered A1/B1 (forward-from-ALU), A2/B2 (PC/immediate) selects and ex_valid for the execute stage, and stalls decode when no forwarding path exists (load-use, older producers not yet written back).

Parameters:
- PIPE_DEPTH, 3, stages from EX up to and including the regfile write (scoreboard length, ≥2).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- id_valid_i  in  1  decode holds a valid instruction
- id_ready_o  out  1  decode instruction accepted this cycle (= ~stall)
- id_rs1_i  in  REG_AW  source register 1
- id_rs2_i  in  REG_AW  source register 2
- id_rs1_used_i  in  1  instruction reads rs1
- id_rs2_used_i  in  1  instruction reads rs2
- id_rd_i  in  REG_AW  destination register
- id_we_i  in  1  instruction writes rd
- id_is_load_i  in  1  result comes from memory, not the ALU
- id_use_pc_i  in  1  ALU operand A is PC
- id_use_imm_i  in  1  ALU operand B is immediate
- flush_i  in  1  taken branch/jump: kill decode instruction
- ex_valid_o  out  1  execute stage holds a valid instruction
- A1_sel_o  out  1  operand1 from ALU result
- B1_sel_o  out  1  operand2/store data from ALU result
- A2_sel_o  out  1  ALU A = PC
- B2_sel_o  out  1  ALU B = immediate
- stall_o  out  1  decode stalled (combinational)

Behaviour:
- Scoreboard: shift register sb[0..PIPE_DEPTH-1] of {valid, rd, is_load}. sb[0] is the instruction in EX. It shifts every cycle; sb[PIPE_DEPTH-1] drops out once its regfile write is visible.
- Entry inserted at sb[0]:
  - On issue (id_valid_i & id_ready_o & ~flush_i): {id_we_i & (id_rd_i≠0), id_rd_i, id_is_load_i}.
  - Otherwise: bubble (valid=0).
- Match(rs, k): rs used, rs≠0, sb[k].valid, sb[k].rd==rs. x0 never matches.
- Forward: Match(rs, 0) & ~sb[0].is_load. The ALU result is available via the alu path next cycle.
- Stall: id_valid_i & ~flush_i & (any Match(rs, 0) with sb[0].is_load, or any Match(rs, k) with k≥1), for rs1 or rs2.
- id_ready_o = ~stall_o. Flush has priority over stall: stall_o=0 when flush_i.
- Issue register (single-cycle latency):
  - On issue: A1_sel_o/B1_sel_o take their forward bits, A2_sel_o=id_use_pc_i, B2_sel_o=id_use_imm_i, ex_valid_o=1.
  - Otherwise: all selects 0, ex_valid_o=0 (bubble).
- A stall holds decode; the stall ends automatically when the producer shifts out. Load-use stall lasts PIPE_DEPTH cycles; a k-position dependency lasts PIPE_DEPTH-k cycles.
- B1_sel_o also drives the store-data forward path, so it is computed whenever rs2 is used, independent of B2_sel_o.
- Flush: also clears sb[0] on the same edge (wrong-path instruction in EX squashed). Older entries are unaffected.
- Reset (async): all sb.valid=0; all selects 0; ex_valid_o=0. Outputs are valid the first cycle after deassertion. Reset mid-stall drops the stalled instruction's state; the stall deasserts immediately.
- Only simultaneous valid matches at multiple positions matter: the youngest (smallest k) rule wins for forwarding, and any k≥1 match stalls.

Optional Feature:
- FWD_HAZARD_CTRL_PERF_EN: adds outputs perf_stall_cnt_o[31:0] and perf_fwd_cnt_o[31:0].
  - perf_stall_cnt_o counts stall cycles.
  - perf_fwd_cnt_o counts issued instructions with A1 or B1 forwarded.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Without the macro these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package fwd_pkg holds: REG_AW default, typedef sb_entry_t {valid, rd, is_load}, constant REG_ZERO.
- One natural sub-module, fwd_scoreboard: shift pipe plus per-position match vectors for rs1/rs2. Forward/stall decision and issue register live in the top.

Test Plan:
- `addi x1,x0,5` then `add x2,x1,x1` back-to-back -> second issues with A1_sel_o=1, B1_sel_o=1, no stall.
- `lw x3,0(x0)` then `add x4,x3,x0` -> stall_o=1 for 3 cycles (PIPE_DEPTH=3), then issue with A1_sel_o=0.
- Dependency on rd=x0 (`addi x0,...` then `add x5,x0,x0`) -> no forward, no stall.
- Producer, unrelated instruction, then consumer of producer's rd -> consumer stalls 2 cycles (k=1), then issues without forward.
- flush_i asserted during load-use stall -> stall_o drops that cycle, ex_valid_o=0 next cycle, sb[0] cleared.
- `auipc`/`sw` with id_use_pc_i=1, id_use_imm_i=1, rs2 forwarded -> A2_sel_o=1, B2_sel_o=1, B1_sel_o=1. Assert rst mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
package fwd_pkg;

  localparam int REG_AW_DEF = 5;
  // Scoreboard rd field is sized for the widest register file this block supports.
  localparam int RD_W = 8;
  localparam logic [RD_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_scoreboard.sv
// In-flight destination pipe (sb[0] = EX) with per-position source-register match vectors.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = REG_AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  sb_entry_t             ins,
  input  logic [REG_AW-1:0]     rs1,
  input  logic [REG_AW-1:0]     rs2,
  output logic [PIPE_DEPTH-1:0] match1,
  output logic [PIPE_DEPTH-1:0] match2,
  output logic                  head_is_load
);

  sb_entry_t       sb_reg [PIPE_DEPTH];
  sb_entry_t       sb_in  [PIPE_DEPTH];
  logic [RD_W-1:0] rs1_ext;
  logic [RD_W-1:0] rs2_ext;

  assign rs1_ext      = RD_W'(rs1);
  assign rs2_ext      = RD_W'(rs2);
  assign head_is_load = sb_reg[0].is_load;

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign sb_in[gi] = ins;
      end else begin : g_tail
        assign sb_in[gi] = sb_reg[gi-1];
      end
      // x0 never matches, so a write to x0 can never create a hazard.
      assign match1[gi] = sb_reg[gi].valid && (rs1_ext != REG_ZERO) && (sb_reg[gi].rd == rs1_ext);
      assign match2[gi] = sb_reg[gi].valid && (rs2_ext != REG_ZERO) && (sb_reg[gi].rd == rs2_ext);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) sb_reg[i] <= '0;
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) sb_reg[i] <= sb_in[i];
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode/execute forwarding and hazard controller: stalls decode and registers operand selects.
// Optional FWD_HAZARD_CTRL_PERF_EN adds saturating stall / forward performance counters.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_we_i,
  input  logic              id_is_load_i,
  input  logic              id_use_pc_i,
  input  logic              id_use_imm_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic              A1_sel_o,
  output logic              B1_sel_o,
  output logic              A2_sel_o,
  output logic              B2_sel_o,
  output logic              stall_o
`ifdef FWD_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_fwd_cnt_o
`endif
);

  logic [PIPE_DEPTH-1:0] match1;
  logic [PIPE_DEPTH-1:0] match2;
  logic [PIPE_DEPTH-1:0] use1;
  logic [PIPE_DEPTH-1:0] use2;
  logic                  head_is_load;
  logic                  hazard;
  logic                  issue;
  logic                  fwd_a;
  logic                  fwd_b;
  sb_entry_t             ins;

  fwd_scoreboard #(
    .PIPE_DEPTH(PIPE_DEPTH),
    .REG_AW    (REG_AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .ins         (ins),
    .rs1         (id_rs1_i),
    .rs2         (id_rs2_i),
    .match1      (match1),
    .match2      (match2),
    .head_is_load(head_is_load)
  );

  assign use1 = match1 & {PIPE_DEPTH{id_rs1_used_i}};
  assign use2 = match2 & {PIPE_DEPTH{id_rs2_used_i}};

  // Only an ALU result in EX can be forwarded; a load in EX or anything older must stall.
  assign fwd_a  = use1[0] & ~head_is_load;
  assign fwd_b  = use2[0] & ~head_is_load;
  assign hazard = ((use1[0] | use2[0]) & head_is_load)
                | (|use1[PIPE_DEPTH-1:1]) | (|use2[PIPE_DEPTH-1:1]);

  assign stall_o    = id_valid_i & ~flush_i & hazard;
  assign id_ready_o = ~stall_o;
  assign issue      = id_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    ins = '0;
    if (issue) begin
      ins.valid   = id_we_i & (id_rd_i != '0);
      ins.rd      = RD_W'(id_rd_i);
      ins.is_load = id_is_load_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o <= 1'b0;
      A1_sel_o   <= 1'b0;
      B1_sel_o   <= 1'b0;
      A2_sel_o   <= 1'b0;
      B2_sel_o   <= 1'b0;
    end else begin
      ex_valid_o <= issue;
      A1_sel_o   <= issue & fwd_a;
      B1_sel_o   <= issue & fwd_b;
      A2_sel_o   <= issue & id_use_pc_i;
      B2_sel_o   <= issue & id_use_imm_i;
    end
  end

`ifdef FWD_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt_o <= '0;
      perf_fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && (perf_stall_cnt_o != '1)) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (issue && (fwd_a || fwd_b) && (perf_fwd_cnt_o != '1)) perf_fwd_cnt_o <= perf_fwd_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vector table, reset corner case, random vs. model.
module tb_fwd_hazard_ctrl;

  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_ready;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_we, id_is_load, id_use_pc, id_use_imm, flush;
  logic       ex_valid, a1, b1, a2, b2, stall;
`ifdef FWD_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.PIPE_DEPTH(DEPTH), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid_i   (id_valid),
    .id_ready_o   (id_ready),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_rs1_used_i(id_rs1_used),
    .id_rs2_used_i(id_rs2_used),
    .id_rd_i      (id_rd),
    .id_we_i      (id_we),
    .id_is_load_i (id_is_load),
    .id_use_pc_i  (id_use_pc),
    .id_use_imm_i (id_use_imm),
    .flush_i      (flush),
    .ex_valid_o   (ex_valid),
    .A1_sel_o     (a1),
    .B1_sel_o     (b1),
    .A2_sel_o     (a2),
    .B2_sel_o     (b2),
    .stall_o      (stall)
`ifdef FWD_HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cnt_o(perf_stall_cnt),
    .perf_fwd_cnt_o  (perf_fwd_cnt)
`endif
  );

  logic [4:0] regs;
  assign regs = {ex_valid, a1, b1, a2, b2};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic we, input logic ld,
                       input logic pc, input logic imm, input logic fl);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_we = we; id_is_load = ld; id_use_pc = pc; id_use_imm = imm; flush = fl;
  endtask

  // Directed vector table: expected regs = {ex_valid, A1, B1, A2, B2} after the edge.
  typedef struct {
    logic v; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd;
    logic we, ld, pc, imm, fl, st; logic [4:0] regs;
  } vec_t;

  function automatic vec_t mk(input logic v, input int r1, input int r2, input logic u1, input logic u2,
                              input int rd, input logic we, input logic ld, input logic pc,
                              input logic imm, input logic fl, input logic st, input logic [4:0] r);
    vec_t e;
    e.v = v; e.rs1 = 5'(r1); e.rs2 = 5'(r2); e.u1 = u1; e.u2 = u2; e.rd = 5'(rd);
    e.we = we; e.ld = ld; e.pc = pc; e.imm = imm; e.fl = fl; e.st = st; e.regs = r;
    return e;
  endfunction

  // Reference model: list of in-flight writers with their age in cycles since entering EX.
  typedef struct { logic [4:0] rd; logic ld; int age; } inf_t;
  inf_t q[$];

  function automatic logic m_hz(input logic [4:0] rs, input logic used);
    foreach (q[i]) if (used && rs != 0 && q[i].rd == rs && (q[i].age > 0 || q[i].ld)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_fwd(input logic [4:0] rs, input logic used);
    foreach (q[i]) if (used && rs != 0 && q[i].rd == rs && q[i].age == 0 && !q[i].ld) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_advance(input logic push, input logic [4:0] rd, input logic ld);
    inf_t nq[$];
    foreach (q[i]) begin
      inf_t e;
      e = q[i];
      e.age++;
      if (e.age < DEPTH) nq.push_back(e);
    end
    if (push) nq.push_back('{rd: rd, ld: ld, age: 0});
    q = nq;
  endfunction

  vec_t vec [22];

  initial begin
    logic       exp_st, iss, held;
    logic [4:0] exp_regs;

    vec[0]  = mk(1, 0, 0, 1, 0,  1, 1, 0, 0, 1, 0, 0, 5'b10001); // addi x1
    vec[1]  = mk(1, 1, 1, 1, 1,  2, 1, 0, 0, 0, 0, 0, 5'b11100); // add x2,x1,x1
    vec[2]  = mk(1, 0, 0, 1, 0,  3, 1, 1, 0, 1, 0, 0, 5'b10001); // lw x3
    vec[3]  = mk(1, 3, 0, 1, 1,  4, 1, 0, 0, 0, 0, 1, 5'b00000); // add x4,x3,x0
    vec[4]  = mk(1, 3, 0, 1, 1,  4, 1, 0, 0, 0, 0, 1, 5'b00000);
    vec[5]  = mk(1, 3, 0, 1, 1,  4, 1, 0, 0, 0, 0, 1, 5'b00000);
    vec[6]  = mk(1, 3, 0, 1, 1,  4, 1, 0, 0, 0, 0, 0, 5'b10000);
    vec[7]  = mk(1, 0, 0, 1, 0,  0, 1, 0, 0, 1, 0, 0, 5'b10001); // addi x0
    vec[8]  = mk(1, 0, 0, 1, 1,  5, 1, 0, 0, 0, 0, 0, 5'b10000); // add x5,x0,x0
    vec[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b00000);
    vec[10] = mk(1, 0, 0, 1, 0,  6, 1, 0, 0, 1, 0, 0, 5'b10001); // addi x6
    vec[11] = mk(1, 0, 0, 1, 0,  7, 1, 0, 0, 1, 0, 0, 5'b10001); // addi x7
    vec[12] = mk(1, 6, 0, 1, 1,  8, 1, 0, 0, 0, 0, 1, 5'b00000); // add x8,x6,x0
    vec[13] = mk(1, 6, 0, 1, 1,  8, 1, 0, 0, 0, 0, 1, 5'b00000);
    vec[14] = mk(1, 6, 0, 1, 1,  8, 1, 0, 0, 0, 0, 0, 5'b10000);
    vec[15] = mk(1, 0, 0, 1, 0,  9, 1, 1, 0, 1, 0, 0, 5'b10001); // lw x9
    vec[16] = mk(1, 9, 0, 1, 1, 10, 1, 0, 0, 0, 0, 1, 5'b00000); // add x10,x9,x0
    vec[17] = mk(1, 9, 0, 1, 1, 10, 1, 0, 0, 0, 1, 0, 5'b00000); // flushed
    vec[18] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b00000);
    vec[19] = mk(1, 0, 0, 1, 0, 11, 1, 0, 0, 1, 0, 0, 5'b10001); // addi x11
    vec[20] = mk(1, 0, 11, 0, 1, 0, 0, 0, 1, 1, 0, 0, 5'b10111); // pc+imm, rs2=x11 forwarded
    vec[21] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5'b00000);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regs", {3'b0, regs}, 8'h00);
    chk("reset_stall", {6'b0, stall, id_ready}, 8'h01);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vec[i].v, vec[i].rs1, vec[i].rs2, vec[i].u1, vec[i].u2, vec[i].rd,
            vec[i].we, vec[i].ld, vec[i].pc, vec[i].imm, vec[i].fl);
      #1;
      chk($sformatf("vec%0d_stall", i), {6'b0, stall, id_ready}, {6'b0, vec[i].st, ~vec[i].st});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_regs", i), {3'b0, regs}, {3'b0, vec[i].regs});
      $display("vec %0d: stall=%b regs=%b", i, stall, regs);
    end

    // Asynchronous reset in the middle of a load-use stall.
    drive(1, 0, 0, 1, 0, 13, 1, 1, 0, 1, 0);
    @(posedge clk);
    #1;
    drive(1, 13, 0, 1, 1, 14, 1, 0, 0, 0, 0);
    #1;
    chk("rstmid_prestall", {7'b0, stall}, 8'h01);
    rst = 1'b1;
    #1;
    chk("rstmid_stall", {6'b0, stall, id_ready}, 8'h01);
    chk("rstmid_regs", {3'b0, regs}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rstmid_after_stall", {7'b0, stall}, 8'h00);
    @(posedge clk);
    #1;
    chk("rstmid_after_regs", {3'b0, regs}, 8'h10);
    $display("reset-mid-stall sequence: regs=%b", regs);

    // Random stimulus against the model, starting from a clean reset.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    held = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!held) begin
        drive(($urandom % 4) != 0, 5'($urandom % 4), 5'($urandom % 4), 1'($urandom), 1'($urandom),
              5'($urandom % 4), ($urandom % 4) != 0, ($urandom % 3) == 0, 1'($urandom), 1'($urandom), 1'b0);
      end
      flush = (($urandom % 10) == 0);
      exp_st = id_valid & ~flush & (m_hz(id_rs1, id_rs1_used) | m_hz(id_rs2, id_rs2_used));
      iss = id_valid & ~exp_st & ~flush;
      exp_regs = iss ? {1'b1, m_fwd(id_rs1, id_rs1_used), m_fwd(id_rs2, id_rs2_used), id_use_pc, id_use_imm}
                     : 5'b0;
      #1;
      chk($sformatf("rnd%0d_stall", c), {6'b0, stall, id_ready}, {6'b0, exp_st, ~exp_st});
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_regs", c), {3'b0, regs}, {3'b0, exp_regs});
      $display("rnd %0d: v=%b rs1=%0d rs2=%0d rd=%0d ld=%b fl=%b stall=%b regs=%b",
               c, id_valid, id_rs1, id_rs2, id_rd, id_is_load, flush, stall, regs);
      m_advance(iss & id_we & (id_rd != 0), id_rd, id_is_load);
      held = exp_st;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
